// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a small byte FIFO in front.
//
// Bytes written through a valid/ready handshake are queued and sent
// back-to-back (no idle gap between frames), LSB first.
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Reset      synchronous, active-high reset
//   i_Tx_DV      byte valid; write happens when i_Tx_DV & o_Tx_Ready
//   i_Tx_Byte    byte to queue
//   o_Tx_Ready   FIFO not full
//   o_Tx_Serial  registered serial line, idles high
//   o_Tx_Active  high while a frame is on the line
//   o_Tx_Done    one-cycle pulse after the last stop-bit cycle
//   o_Fifo_Count bytes waiting in the FIFO (excludes the byte being shifted)
module uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_AW      = 2
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    input  logic               i_Tx_DV,
    input  logic [7:0]         i_Tx_Byte,
    output logic               o_Tx_Ready,
    output logic               o_Tx_Serial,
    output logic               o_Tx_Active,
    output logic               o_Tx_Done,
    output logic [FIFO_AW:0]   o_Fifo_Count
);

    localparam int                 DEPTH    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [15:0]        LAST_CLK = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t               r_state, w_state_nxt;
    logic [15:0]          r_clk_cnt, w_clk_cnt_nxt;
    logic [2:0]           r_bit_idx, w_bit_idx_nxt;
    logic [7:0]           r_shift;
    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]     r_count;
    logic                 r_serial, r_active, r_done_pre, r_done;
    logic                 w_serial_nxt;
    logic                 w_wr, w_pop, w_bit_end, w_fifo_nempty;

    assign o_Tx_Ready    = (r_count != DEPTH_C);
    assign o_Fifo_Count  = r_count;
    assign o_Tx_Serial   = r_serial;
    assign o_Tx_Active   = r_active;
    assign o_Tx_Done     = r_done;

    // Ready comes from the registered count, so a write while full is
    // dropped even if the FSM pops on the same edge.
    assign w_wr          = i_Tx_DV & o_Tx_Ready;
    assign w_fifo_nempty = (r_count != '0);
    assign w_bit_end     = (r_clk_cnt == LAST_CLK);

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        w_bit_idx_nxt = r_bit_idx;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clk_cnt_nxt = '0;
                if (w_fifo_nempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    // Chain straight into the next frame when bytes wait.
                    if (w_fifo_nempty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_clk_cnt_nxt = '0;
                w_bit_idx_nxt = '0;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end

    // Line value for the current state; registered so it lags state by one
    // cycle, which gives the two-cycle write-to-start latency.
    always_comb begin
        w_serial_nxt = 1'b1;
        case (r_state)
            S_START: w_serial_nxt = 1'b0;
            S_DATA:  w_serial_nxt = r_shift[r_bit_idx];
            default: w_serial_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_serial   <= 1'b1;
            r_active   <= 1'b0;
            r_done_pre <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_cnt  <= w_clk_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_serial   <= w_serial_nxt;
            r_active   <= (r_state != S_IDLE);
            // Extra stage aligns the pulse with the end of the stop bit on
            // the (lagged) line.
            r_done_pre <= (r_state == S_STOP) && w_bit_end;
            r_done     <= r_done_pre;
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end
        end
    end

    // FIFO storage needs no reset; pointers and count define validity.
    always_ff @(posedge i_Clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_Tx_Byte;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one DUT at CLKS_PER_BIT=4, one at 2.
module tb_uart_tx;

    localparam int C4 = 4;
    localparam int C2 = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       dv4 = 1'b0;
    logic [7:0] d4  = 8'h00;
    logic       ready4, ser4, act4, done4;
    logic [2:0] cnt4;

    logic       dv2 = 1'b0;
    logic [7:0] d2  = 8'h00;
    logic       ready2, ser2, act2, done2;
    logic [2:0] cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(C4), .FIFO_AW(2)) dut4 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv4), .i_Tx_Byte(d4),
        .o_Tx_Ready(ready4), .o_Tx_Serial(ser4), .o_Tx_Active(act4),
        .o_Tx_Done(done4), .o_Fifo_Count(cnt4)
    );

    uart_tx #(.CLKS_PER_BIT(C2), .FIFO_AW(2)) dut2 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv2), .i_Tx_Byte(d2),
        .o_Tx_Ready(ready2), .o_Tx_Serial(ser2), .o_Tx_Active(act2),
        .o_Tx_Done(done2), .o_Fifo_Count(cnt2)
    );

    // Bench receivers: sample each bit at its middle, sampled on negedge.
    bit         busy4 = 0, busy2 = 0;
    int         t4, t2;
    logic [7:0] sh4, sh2;
    logic [7:0] rx4[$];
    logic [7:0] rx2[$];
    int         ferr4 = 0, ferr2 = 0;
    int         done4_n = 0;

    always @(negedge clk) begin
        if (rst) busy4 = 0;
        else if (!busy4) begin
            if (ser4 === 1'b0) begin busy4 = 1; t4 = 0; sh4 = 8'h00; end
        end else begin
            t4 = t4 + 1;
            if (t4 >= C4 && t4 < 9*C4 && (t4 % C4) == C4/2) sh4 = {ser4, sh4[7:1]};
            if (t4 == 9*C4 + C4/2) begin
                if (ser4 !== 1'b1) ferr4++;
                rx4.push_back(sh4);
            end
            if (t4 == 10*C4 - 1) busy4 = 0;
        end
        if (done4 === 1'b1) done4_n++;
    end

    always @(negedge clk) begin
        if (rst) busy2 = 0;
        else if (!busy2) begin
            if (ser2 === 1'b0) begin busy2 = 1; t2 = 0; sh2 = 8'h00; end
        end else begin
            t2 = t2 + 1;
            if (t2 >= C2 && t2 < 9*C2 && (t2 % C2) == C2/2) sh2 = {ser2, sh2[7:1]};
            if (t2 == 9*C2 + C2/2) begin
                if (ser2 !== 1'b1) ferr2++;
                rx2.push_back(sh2);
            end
            if (t2 == 10*C2 - 1) busy2 = 0;
        end
    end

    // Expected line level s cycles after a frame's first start-bit cycle (C=4).
    function automatic logic exp_line(input logic [7:0] b, input int s);
        if (s < 0 || s >= 40) return 1'b1;
        if (s < 4)            return 1'b0;
        if (s < 36)           return b[(s-4)/4];
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({ser4, act4, ready4, done4, cnt4} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd0}) begin
                n_err++;
                $display("FAIL reset_idle k=%0d: got ser/act/rdy/done/cnt=%b%b%b%b/%0d expected 1010/0",
                         k, ser4, act4, ready4, done4, cnt4);
            end
        end
        n_cmp++;
        if ({ser2, act2, ready2, cnt2} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL reset_idle_c2: got %b%b%b/%0d expected 101/0", ser2, act2, ready2, cnt2);
        end
    endtask

    task automatic test_single();
        logic es, ea, ed;
        rx4.delete(); done4_n = 0;
        dv4 = 1'b1; d4 = 8'hA5;
        @(posedge clk);
        #1 dv4 = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            es = exp_line(8'hA5, k-2);
            ea = (k >= 2 && k < 42);
            ed = (k == 42);
            n_cmp++;
            if ({ser4, act4, done4} !== {es, ea, ed}) begin
                n_err++;
                $display("FAIL single_wave k=%0d: got ser/act/done=%b%b%b expected %b%b%b",
                         k, ser4, act4, done4, es, ea, ed);
            end
            if (k < 2) begin
                n_cmp++;
                if (cnt4 !== (k == 0 ? 3'd1 : 3'd0)) begin
                    n_err++;
                    $display("FAIL single_count k=%0d: got %0d expected %0d", k, cnt4, (k == 0 ? 1 : 0));
                end
            end
        end
        n_cmp++;
        if (rx4.size() != 1 || rx4[0] !== 8'hA5) begin
            n_err++;
            $display("FAIL single_decode: got %0d bytes first %h expected 1 byte a5",
                     rx4.size(), (rx4.size() > 0) ? rx4[0] : 8'hxx);
        end
        n_cmp++;
        if (done4_n != 1) begin
            n_err++;
            $display("FAIL single_done_count: got %0d expected 1", done4_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic es, ea, ed;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
        rx4.delete(); done4_n = 0; ferr4 = 0;
        dv4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d4 = bytes[i];
            @(posedge clk);
            #1;
        end
        dv4 = 1'b0;
        for (int k = 2; k < 132; k++) begin
            @(negedge clk);
            if (k - 2 < 120) es = exp_line(bytes[(k-2)/40], (k-2) % 40);
            else             es = 1'b1;
            ea = (k >= 2 && k < 122);
            ed = (k == 42 || k == 82 || k == 122);
            n_cmp++;
            if ({ser4, act4, done4} !== {es, ea, ed}) begin
                n_err++;
                $display("FAIL b2b_wave k=%0d: got ser/act/done=%b%b%b expected %b%b%b",
                         k, ser4, act4, done4, es, ea, ed);
            end
        end
        n_cmp++;
        if (rx4.size() != 3) begin
            n_err++;
            $display("FAIL b2b_nbytes: got %0d expected 3", rx4.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (rx4[i] !== bytes[i]) begin
                    n_err++;
                    $display("FAIL b2b_byte%0d: got %h expected %h", i, rx4[i], bytes[i]);
                end
            end
        end
        n_cmp++;
        if (done4_n != 3 || ferr4 != 0) begin
            n_err++;
            $display("FAIL b2b_done_framing: got done=%0d ferr=%0d expected 3/0", done4_n, ferr4);
        end
    endtask

    task automatic test_fill();
        logic [7:0] bytes [6];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h66;
        rx4.delete(); done4_n = 0;
        dv4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d4 = bytes[i];
            @(posedge clk);
            #1;
            if (i == 0) begin
                n_cmp++;
                if (cnt4 !== 3'd1) begin
                    n_err++;
                    $display("FAIL fill_cnt_first: got %0d expected 1", cnt4);
                end
            end
            if (i >= 4) begin
                n_cmp++;
                if (cnt4 !== 3'd4 || ready4 !== 1'b0) begin
                    n_err++;
                    $display("FAIL fill_full i=%0d: got cnt=%0d rdy=%b expected 4/0", i, cnt4, ready4);
                end
            end
        end
        dv4 = 1'b0;
        repeat (5*40 + 30) @(posedge clk);
        #1;
        n_cmp++;
        if (rx4.size() != 5 || done4_n != 5) begin
            n_err++;
            $display("FAIL fill_frames: got %0d bytes %0d done expected 5/5", rx4.size(), done4_n);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (rx4[i] !== bytes[i]) begin
                    n_err++;
                    $display("FAIL fill_byte%0d: got %h expected %h", i, rx4[i], bytes[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        rx4.delete(); done4_n = 0;
        dv4 = 1'b1; d4 = 8'h00;
        @(posedge clk);                // edge N
        #1 d4 = 8'hFF;
        @(posedge clk);                // edge N+1
        #1 dv4 = 1'b0;
        repeat (17) @(posedge clk);    // edge N+18
        #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ser4 !== 1'b0 || act4 !== 1'b1 || cnt4 !== 3'd1) begin
            n_err++;
            $display("FAIL rstmid_before: got ser/act/cnt=%b%b/%0d expected 01/1", ser4, act4, cnt4);
        end
        @(posedge clk);                // reset edge N+19, cycle 17 of the frame
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ser4, act4, ready4, done4, cnt4} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL rstmid_after: got ser/act/rdy/done/cnt=%b%b%b%b/%0d expected 1010/0",
                     ser4, act4, ready4, done4, cnt4);
        end
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ser4 !== 1'b1 || act4 !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_quiet k=%0d: got ser/act=%b%b expected 10", k, ser4, act4);
            end
        end
        n_cmp++;
        if (rx4.size() != 0 || done4_n != 0) begin
            n_err++;
            $display("FAIL rstmid_noframe: got %0d bytes %0d done expected 0/0", rx4.size(), done4_n);
        end
    endtask

    task automatic test_stream();
        logic [7:0] acc[$];
        logic [7:0] nxt;
        logic       rdy;
        bit         saw_full;
        nxt = 8'h00; saw_full = 0;
        rx2.delete(); ferr2 = 0;
        dv2 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            d2  = nxt;
            rdy = ready2;
            if (cnt2 == 3'd4) saw_full = 1;
            n_cmp++;
            if (ready2 !== (cnt2 != 3'd4) || cnt2 > 3'd4) begin
                n_err++;
                $display("FAIL stream_ready i=%0d: got rdy=%b cnt=%0d expected rdy=(cnt!=4), cnt<=4", i, ready2, cnt2);
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                acc.push_back(nxt);
                nxt = nxt + 8'd1;
            end
        end
        dv2 = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        n_cmp++;
        if (!saw_full || acc.size() <= 4) begin
            n_err++;
            $display("FAIL stream_wrap: got full_seen=%0d accepted=%0d expected 1 and >4", saw_full, acc.size());
        end
        n_cmp++;
        if (rx2.size() != acc.size() || ferr2 != 0) begin
            n_err++;
            $display("FAIL stream_count: got %0d decoded ferr=%0d expected %0d/0", rx2.size(), ferr2, acc.size());
        end else begin
            for (int i = 0; i < acc.size(); i++) begin
                n_cmp++;
                if (rx2[i] !== acc[i]) begin
                    n_err++;
                    $display("FAIL stream_byte%0d: got %h expected %h", i, rx2[i], acc[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_reset_mid();
        test_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for the UART link, the counterpart of the UART receiver.
- Format is 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- Bytes are accepted through a valid/ready handshake into a small internal FIFO, so the host can queue several bytes.
- Queued bytes are sent back-to-back with no idle gap between frames.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per serial bit = f(i_Clock)/baud (e.g. 10 MHz / 115200 = 87); legal range 2..65535.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (default 4).

Ports:
- i_Clock  input  1  system clock; all logic on the rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Tx_DV  input  1  byte valid; a write occurs when i_Tx_DV=1 and o_Tx_Ready=1 at the clock edge.
- i_Tx_Byte  input  8  byte to transmit, sampled on a write.
- o_Tx_Ready  output  1  FIFO not full.
- o_Tx_Serial  output  1  serial line, registered; idles high.
- o_Tx_Active  output  1  high while a frame is on the line.
- o_Tx_Done  output  1  one-cycle pulse at the end of each stop bit.
- o_Fifo_Count  output  FIFO_AW+1  number of queued bytes, not counting the byte being shifted.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high, and has priority over everything else.
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, o_Fifo_Count=0. State=IDLE, bit counter=0, bit index=0, FIFO pointers=0.
- Reset mid-frame: the frame is aborted and the line is high from the cycle after the reset edge. The FIFO is flushed and no o_Tx_Done pulse is produced.
- FIFO write: when i_Tx_DV & o_Tx_Ready, store the byte at the write pointer and increment the write pointer (wraps modulo depth).
- o_Tx_Ready = (count != depth), computed from registered count.
  - A write attempted while full is dropped, even if a pop happens in the same cycle.
- Simultaneous write and pop when not full: count unchanged, both pointers advance.
- Pop: the FSM reads the entry at the read pointer, loads it into the shift register and increments the read pointer (wraps).
- Clock counter: 16-bit, counts 0..CLKS_PER_BIT-1 within each bit and resets to 0 at each bit boundary. Every bit lasts exactly CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: line=1, Active=0. If count>0, pop and go to START; the line goes 0 in the next cycle, Active=1. Latency from a write into an empty FIFO (write edge N) to the line going low is 2 cycles (low from edge N+2).
  - START: hold line=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0 and line=shift[0].
  - DATA: hold each bit for CLKS_PER_BIT cycles. At the end of bit i<7, increment the index and drive shift[i+1]. At the end of bit 7, reset the index to 0, go to STOP, line=1.
  - STOP: hold line=1 for CLKS_PER_BIT cycles. At the last cycle, o_Tx_Done=1 for the next cycle only. Then:
    - If count>0, pop in the same edge and go directly to START (line=0 next cycle, Active stays 1). Frame period is exactly 10*CLKS_PER_BIT.
    - Else go to IDLE with Active=0.
  - Any illegal state: go to IDLE with line=1.
- Data capture: the byte is captured at pop. Later FIFO writes never alter the frame in flight.
- o_Tx_Active: high continuously across back-to-back frames.

Test Plan:
- Reset, then idle for 20 cycles -> o_Tx_Serial=1, Active=0, Ready=1, Fifo_Count=0 throughout.
- CLKS_PER_BIT=4, write 0xA5 once into an empty FIFO at edge N -> line low from N+2 for 4 cycles. Then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. Done pulses exactly once, Active high for 40 cycles. A bench receiver decodes 0xA5.
- CLKS_PER_BIT=4, write 0x00, 0xFF, 0x3C on consecutive cycles -> three frames with no idle gap (period 40 cycles each), Active never drops. Done pulses at cycles 40, 80 and 120 after the first start edge. Bytes are decoded in order.
- Fill test: write 6 bytes back-to-back -> first pops immediately, next 4 fill the FIFO (Fifo_Count=4, Ready=0), sixth is dropped. Exactly 5 frames are sent.
- Reset asserted at cycle 17 of a frame -> line=1 the next cycle, Fifo_Count=0, no Done pulse, no further frames.
- CLKS_PER_BIT=2, keep i_Tx_DV high with an incrementing byte for 200 cycles -> accepted bytes are transmitted in order with no loss or duplication. Ready toggles only with count=depth, and pointer wrap is exercised.
